uart_tx_arbiter: RTL and testbench

- Shares the single UART transmitter between three message sources: RX echo, rate-change report and scroller-start notice.
- Grants one source at a time, round-robin, and holds the grant for a whole framed message.
- Each frame is a header byte, then the payload bytes, then a terminator byte.
- Sits between the message sources and UART_TX; bytes move on a valid/ready handshake, with ready driven from the transmitter's idle status.

---
 rtl/uart_tx_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART transmitter between NUM_REQ message sources. Sources are
// granted round-robin. A granted source keeps the transmitter for a whole
// framed message: a header byte (8'h40 + source index), then up to MAX_LEN
// payload bytes, then TERM_BYTE. Bytes move on a valid/ready handshake with
// the transmitter. A transfer stalled for TIMEOUT cycles aborts the frame.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-low reset
//   iREQ       level request per source, held until that source's oDONE/oERR
//   iLEN       4-bit payload length per source, sampled at grant
//   iDATA      current payload byte per source, stable while granted
//   oGRANT     one-hot grant, held for the whole frame
//   oDATA_RD   strobe: granted source's byte consumed this cycle
//   oDONE      one-cycle pulse after the terminator is accepted
//   oERR       one-cycle pulse on timeout abort
//   oTX_DATA   byte to the transmitter
//   oTX_VALID  oTX_DATA is valid
//   iTX_READY  transmitter accepts the byte this cycle
//   oBUSY      high whenever a frame is in progress
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int          NUM_REQ   = 3,
    parameter int          MAX_LEN   = 8,
    parameter int          TIMEOUT   = 50000,
    parameter logic [7:0]  TERM_BYTE = 8'h0D
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     iREQ,
    input  logic [4*NUM_REQ-1:0]   iLEN,
    input  logic [8*NUM_REQ-1:0]   iDATA,
    output logic [NUM_REQ-1:0]     oGRANT,
    output logic [NUM_REQ-1:0]     oDATA_RD,
    output logic [NUM_REQ-1:0]     oDONE,
    output logic                   oERR,
    output logic [7:0]             oTX_DATA,
    output logic                   oTX_VALID,
    input  logic                   iTX_READY,
    output logic                   oBUSY
);

    localparam int              IW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IW:0]     NREQ_W     = (IW+1)'(NUM_REQ);
    localparam logic [3:0]      MAX_LEN_W  = 4'(MAX_LEN);
    localparam logic [15:0]     WAIT_LIMIT = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        PAYLOAD,
        TERM
    } state_t;

    state_t                 r_state;
    logic [NUM_REQ-1:0]     r_grant;
    logic [IW-1:0]          r_ptr;
    logic [3:0]             r_len;
    logic [3:0]             r_count;
    logic [15:0]            r_wait;
    logic                   r_txValid;
    logic                   r_busy;
    logic [NUM_REQ-1:0]     r_done;
    logic                   r_err;

    logic                   w_found;
    logic [IW-1:0]          w_pick;
    logic [NUM_REQ-1:0]     w_pickOh;
    logic [3:0]             w_pickLen;
    logic [3:0]             w_clampLen;
    logic                   w_accept;
    logic                   w_timeout;

    // Round-robin search: the first requesting source strictly after the
    // pointer, wrapping. The pointer holds the last granted source, so that
    // source is checked last.
    always_comb begin
        logic [IW:0] w_sum;
        w_found = 1'b0;
        w_pick  = '0;
        w_sum   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_sum = {1'b0, r_ptr} + (IW+1)'(i + 1);
            if (w_sum >= NREQ_W) begin
                w_sum = w_sum - NREQ_W;
            end
            if (!w_found && iREQ[w_sum[IW-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_sum[IW-1:0];
            end
        end
    end

    // Length is clamped once at grant, so later iLEN changes cannot matter.
    always_comb begin
        w_pickOh   = NUM_REQ'(1) << w_pick;
        w_pickLen  = iLEN[{w_pick, 2'b00} +: 4];
        w_clampLen = (w_pickLen > MAX_LEN_W) ? MAX_LEN_W : w_pickLen;
    end

    assign w_accept  = r_txValid && iTX_READY;
    assign w_timeout = r_txValid && !iTX_READY && (r_wait == WAIT_LIMIT);

    // Framing FSM. The transmitter ready is only ever looked at together
    // with our own valid, so nothing moves while idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_grant   <= '0;
            r_ptr     <= IW'(NUM_REQ - 1);
            r_len     <= '0;
            r_count   <= '0;
            r_wait    <= '0;
            r_txValid <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= '0;
            r_err     <= 1'b0;
        end else begin
            r_done <= '0;
            r_err  <= 1'b0;

            if (r_txValid && !iTX_READY) begin
                r_wait <= r_wait + 16'd1;
            end else begin
                r_wait <= '0;
            end

            if (w_timeout) begin
                // Abort: pointer stays on the stalled source so it drops to
                // lowest priority for the next arbitration.
                r_state   <= IDLE;
                r_grant   <= '0;
                r_txValid <= 1'b0;
                r_busy    <= 1'b0;
                r_err     <= 1'b1;
                r_wait    <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_found) begin
                            r_grant   <= w_pickOh;
                            r_ptr     <= w_pick;
                            r_len     <= w_clampLen;
                            r_state   <= HDR;
                            r_txValid <= 1'b1;
                            r_busy    <= 1'b1;
                        end
                    end
                    HDR: begin
                        if (w_accept) begin
                            if (r_len == 4'd0) begin
                                r_state <= TERM;
                            end else begin
                                r_state <= PAYLOAD;
                                r_count <= r_len;
                            end
                        end
                    end
                    PAYLOAD: begin
                        if (w_accept) begin
                            r_count <= r_count - 4'd1;
                            if (r_count == 4'd1) begin
                                r_state <= TERM;
                            end
                        end
                    end
                    TERM: begin
                        if (w_accept) begin
                            r_state   <= IDLE;
                            r_grant   <= '0;
                            r_done    <= r_grant;
                            r_txValid <= 1'b0;
                            r_busy    <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    // Byte presented to the transmitter; payload comes straight from the
    // granted source so the source can advance right after its read strobe.
    always_comb begin
        oTX_DATA = 8'h00;
        case (r_state)
            HDR:     oTX_DATA = 8'h40 + 8'(r_ptr);
            PAYLOAD: oTX_DATA = iDATA[{r_ptr, 3'b000} +: 8];
            TERM:    oTX_DATA = TERM_BYTE;
            default: oTX_DATA = 8'h00;
        endcase
    end

    assign oDATA_RD  = (r_state == PAYLOAD && w_accept) ? r_grant : '0;
    assign oGRANT    = r_grant;
    assign oDONE     = r_done;
    assign oERR      = r_err;
    assign oTX_VALID = r_txValid;
    assign oBUSY     = r_busy;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed bench for uart_tx_arbiter with hand-computed expected streams.
// Inputs change just after the falling edge; outputs are read 1ns later.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    logic         clk;
    logic         reset;
    logic [2:0]   iREQ;
    logic [11:0]  iLEN;
    logic [23:0]  iDATA;
    logic [2:0]   oGRANT;
    logic [2:0]   oDATA_RD;
    logic [2:0]   oDONE;
    logic         oERR;
    logic [7:0]   oTX_DATA;
    logic         oTX_VALID;
    logic         iTX_READY;
    logic         oBUSY;

    int           vectorCount = 0;
    int           errorCount  = 0;

    logic [7:0]   capQ[$];
    int           rdCount;
    int           doneCount;
    int           idleCount;

    uart_tx_arbiter #(
        .NUM_REQ   (3),
        .MAX_LEN   (8),
        .TIMEOUT   (20),
        .TERM_BYTE (8'h0D)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .iREQ      (iREQ),
        .iLEN      (iLEN),
        .iDATA     (iDATA),
        .oGRANT    (oGRANT),
        .oDATA_RD  (oDATA_RD),
        .oDONE     (oDONE),
        .oERR      (oERR),
        .oTX_DATA  (oTX_DATA),
        .oTX_VALID (oTX_VALID),
        .iTX_READY (iTX_READY),
        .oBUSY     (oBUSY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] req, input logic [11:0] len,
                                 input logic [23:0] data, input logic ready);
        iREQ      = req;
        iLEN      = len;
        iDATA     = data;
        iTX_READY = ready;
    endtask

    // Collects accepted bytes until nBytes arrive or the cycle budget runs out.
    task automatic captureBytes(input int nBytes, input int budget);
        capQ.delete();
        rdCount   = 0;
        doneCount = 0;
        idleCount = 0;
        for (int c = 0; c < budget && capQ.size() < nBytes; c++) begin
            @(negedge clk);
            #1;
            rdCount += $countones(oDATA_RD);
            if (oDONE != 3'b000) doneCount++;
            if (!oBUSY && capQ.size() > 0) idleCount++;
            if (oTX_VALID && iTX_READY) capQ.push_back(oTX_DATA);
        end
    endtask

    initial begin
        logic [7:0] expRr[12];
        int         stallRd;
        int         stallBad;
        int         errAt;

        expRr = '{8'h40, 8'h50, 8'h0D, 8'h41, 8'h51, 8'h0D,
                  8'h42, 8'h52, 8'h0D, 8'h40, 8'h50, 8'h0D};

        reset = 1'b0;
        applyStimulus(3'b000, 12'h000, 24'h000000, 1'b0);
        @(negedge clk);
        #1;
        checkOutput("reset grant", oGRANT, 3'b000);
        checkOutput("reset valid", oTX_VALID, 1'b0);
        checkOutput("reset busy", oBUSY, 1'b0);
        checkOutput("reset txdata", oTX_DATA, 8'h00);
        checkOutput("reset done/err", {oDONE, oERR}, 4'h0);
        reset = 1'b1;

        // Round-robin with all three requesting, one payload byte each.
        @(negedge clk);
        #1;
        applyStimulus(3'b111, {4'd1, 4'd1, 4'd1}, {8'h52, 8'h51, 8'h50}, 1'b1);
        captureBytes(12, 60);
        checkOutput("rr byte count", capQ.size(), 12);
        for (int i = 0; i < 12; i++) begin
            if (i < capQ.size()) checkOutput($sformatf("rr byte %0d", i), capQ[i], expRr[i]);
        end
        checkOutput("rr data reads", rdCount, 4);
        checkOutput("rr done pulses", doneCount, 3);
        checkOutput("rr idle gaps", idleCount, 3);
        iREQ = 3'b000;
        @(negedge clk);
        #1;
        checkOutput("rr last done", oDONE, 3'b001);

        // Source 1, two payload bytes, source advances on each read strobe.
        applyStimulus(3'b010, {4'd0, 4'd2, 4'd0}, {8'h00, 8'h31, 8'h00}, 1'b1);
        #1;
        checkOutput("t1 no grant yet", oGRANT, 3'b000);
        @(negedge clk);
        #1;
        checkOutput("t1 grant", oGRANT, 3'b010);
        checkOutput("t1 header", oTX_DATA, 8'h41);
        checkOutput("t1 busy", oBUSY, 1'b1);
        @(negedge clk);
        #1;
        checkOutput("t1 byte0", oTX_DATA, 8'h31);
        checkOutput("t1 rd0", oDATA_RD, 3'b010);
        @(negedge clk);
        iDATA = {8'h00, 8'h32, 8'h00};
        #1;
        checkOutput("t1 byte1", oTX_DATA, 8'h32);
        checkOutput("t1 rd1", oDATA_RD, 3'b010);
        @(negedge clk);
        #1;
        checkOutput("t1 term", oTX_DATA, 8'h0D);
        checkOutput("t1 term no rd", oDATA_RD, 3'b000);
        iREQ = 3'b000;
        @(negedge clk);
        #1;
        checkOutput("t1 done", oDONE, 3'b010);
        checkOutput("t1 grant cleared", oGRANT, 3'b000);
        checkOutput("t1 valid cleared", oTX_VALID, 1'b0);

        // Zero-length frame on source 2.
        applyStimulus(3'b100, {4'd0, 4'd0, 4'd0}, {8'hAA, 8'h00, 8'h00}, 1'b1);
        captureBytes(2, 10);
        checkOutput("len0 count", capQ.size(), 2);
        if (capQ.size() == 2) begin
            checkOutput("len0 header", capQ[0], 8'h42);
            checkOutput("len0 term", capQ[1], 8'h0D);
        end
        checkOutput("len0 no reads", rdCount, 0);
        iREQ = 3'b000;
        @(negedge clk);
        #1;
        checkOutput("len0 done", oDONE, 3'b100);

        // Length 15 is clamped to 8 payload bytes.
        applyStimulus(3'b001, {4'd0, 4'd0, 4'hF}, {8'h00, 8'h00, 8'h77}, 1'b1);
        captureBytes(10, 30);
        checkOutput("clamp count", capQ.size(), 10);
        if (capQ.size() == 10) begin
            checkOutput("clamp header", capQ[0], 8'h40);
            checkOutput("clamp first", capQ[1], 8'h77);
            checkOutput("clamp last", capQ[8], 8'h77);
            checkOutput("clamp term", capQ[9], 8'h0D);
        end
        checkOutput("clamp reads", rdCount, 8);
        iREQ = 3'b000;
        @(negedge clk);
        #1;
        checkOutput("clamp done", oDONE, 3'b001);

        // Backpressure for 10 cycles in the middle of a 3-byte payload.
        applyStimulus(3'b001, {4'd0, 4'd0, 4'd3}, {8'h00, 8'h00, 8'h55}, 1'b1);
        @(negedge clk);
        #1;
        checkOutput("bp header", oTX_DATA, 8'h40);
        @(negedge clk);
        #1;
        checkOutput("bp rd0", oDATA_RD, 3'b001);
        @(negedge clk);
        iTX_READY = 1'b0;
        stallRd  = 0;
        stallBad = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            stallRd += $countones(oDATA_RD);
            if (oTX_DATA != 8'h55 || !oTX_VALID) stallBad++;
            @(negedge clk);
        end
        #1;
        checkOutput("bp stall reads", stallRd, 0);
        checkOutput("bp stall data", stallBad, 0);
        checkOutput("bp grant held", oGRANT, 3'b001);
        iTX_READY = 1'b1;
        #1;
        checkOutput("bp resume rd", oDATA_RD, 3'b001);
        captureBytes(2, 10);
        checkOutput("bp tail count", capQ.size(), 2);
        if (capQ.size() == 2) begin
            checkOutput("bp tail byte", capQ[0], 8'h55);
            checkOutput("bp tail term", capQ[1], 8'h0D);
        end
        iREQ = 3'b000;
        @(negedge clk);
        #1;
        checkOutput("bp done", oDONE, 3'b001);

        // Timeout: source 0 stalls, source 1 joins and must win afterwards.
        applyStimulus(3'b001, {4'd0, 4'd3, 4'd1}, {8'h00, 8'h33, 8'h11}, 1'b0);
        @(negedge clk);
        #1;
        checkOutput("to grant", oGRANT, 3'b001);
        iREQ  = 3'b011;
        errAt = 0;
        for (int k = 1; k <= 40 && errAt == 0; k++) begin
            @(negedge clk);
            #1;
            if (oERR) errAt = k;
        end
        checkOutput("to err cycle", errAt, 20);
        checkOutput("to grant cleared", oGRANT, 3'b000);
        checkOutput("to valid cleared", oTX_VALID, 1'b0);
        checkOutput("to no done", oDONE, 3'b000);
        @(negedge clk);
        #1;
        checkOutput("to next grant", oGRANT, 3'b010);
        checkOutput("to next header", oTX_DATA, 8'h41);

        // Reset in the middle of the payload.
        iTX_READY = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("rst payload byte", oTX_DATA, 8'h33);
        #3;
        reset = 1'b0;
        #1;
        checkOutput("rst grant", oGRANT, 3'b000);
        checkOutput("rst valid", oTX_VALID, 1'b0);
        checkOutput("rst busy", oBUSY, 1'b0);
        checkOutput("rst txdata", oTX_DATA, 8'h00);
        checkOutput("rst rd", oDATA_RD, 3'b000);
        @(negedge clk);
        applyStimulus(3'b110, {4'd1, 4'd1, 4'd1}, {8'h22, 8'h33, 8'h11}, 1'b1);
        reset = 1'b1;
        #1;
        checkOutput("rst no grant yet", oGRANT, 3'b000);
        @(negedge clk);
        #1;
        checkOutput("rst first grant", oGRANT, 3'b010);
        checkOutput("rst first header", oTX_DATA, 8'h41);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, errorCount);
        $finish;
    end

endmodule
